// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, stage payload layout and chunking check for the pipelined adder
package adder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  // Payload carried between stages at the default width; adder_stage keeps the same field set.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [WIDTH_DEF-1:0] sum;
  } stage_t;

  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one CHUNK-wide ripple segment with its pipeline register and ready logic
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic             dn_carry,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_sum
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   seg;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    seg      = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]} + {{CHUNK{1'b0}}, up_carry};
    sum_next = up_sum;
    sum_next[LO +: CHUNK] = seg[CHUNK-1:0];
  end

  // An empty register can always refill, which lets bubbles collapse under a stalled output.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_carry <= 1'b0;
      dn_a     <= '0;
      dn_b     <= '0;
      dn_sum   <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_carry <= seg[CHUNK];
        dn_a     <= up_a;
        dn_b     <= up_b;
        dn_sum   <= sum_next;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract split into WIDTH/CHUNK pipelined ripple stages
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunking
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  logic [STAGES:0]  v;
  logic [STAGES:0]  c;
  logic [STAGES:0]  r;
  logic [WIDTH-1:0] a [STAGES+1];
  logic [WIDTH-1:0] b [STAGES+1];
  logic [WIDTH-1:0] s [STAGES+1];

  // Subtraction is A + ~B + 1, so the caller's carry-in is overridden.
  assign v[0] = bus.in_valid;
  assign c[0] = bus.in_sub | bus.in_cin;
  assign a[0] = bus.in_a;
  assign b[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign s[0] = '0;

  assign r[STAGES]    = bus.out_ready;
  assign bus.in_ready = r[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[k]),
      .up_ready (r[k]),
      .up_carry (c[k]),
      .up_a     (a[k]),
      .up_b     (b[k]),
      .up_sum   (s[k]),
      .dn_valid (v[k+1]),
      .dn_ready (r[k+1]),
      .dn_carry (c[k+1]),
      .dn_a     (a[k+1]),
      .dn_b     (b[k+1]),
      .dn_sum   (s[k+1])
    );
  end

  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered from the registered bits.
  logic msb_cin;
  assign msb_cin = a[STAGES][WIDTH-1] ^ b[STAGES][WIDTH-1] ^ s[STAGES][WIDTH-1];

  assign bus.out_valid = v[STAGES];
  assign bus.out_sum   = s[STAGES];
  assign bus.out_cout  = c[STAGES];
  assign bus.out_ovf   = c[STAGES] ^ msb_cin;

  logic unused_operand_bits;
  assign unused_operand_bits = ^{a[STAGES][WIDTH-2:0], b[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and streaming checks of the pipelined adder
module tb_pipelined_adder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pipelined_adder_if #(.WIDTH(32)) bus ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(output bit acc, output bit pop, output logic [31:0] ps,
                      output bit pc, output bit po);
    #1;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    ps  = bus.out_sum;
    pc  = bus.out_cout;
    po  = bus.out_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input bit cin, input bit sub);
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_cin = cin;
    bus.in_sub = sub;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input bit cin, input bit sub,
                         output logic [31:0] s, output bit co, output bit ov, output bit got);
    bit acc, pop, pc, po;
    logic [31:0] ps;
    got = 1'b0;
    s = '0; co = 1'b0; ov = 1'b0;
    set_ops(a, b, cin, sub);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      tick(acc, pop, ps, pc, po);
      if (acc) bus.in_valid = 1'b0;
      if (pop) begin
        got = 1'b1; s = ps; co = pc; ov = po;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit cin, input bit sub);
    logic [31:0] be;
    logic [32:0] rr;
    logic        ov;
    be = sub ? ~b : b;
    rr = {1'b0, a} + {1'b0, be} + 33'(sub ? 1'b1 : cin);
    ov = (a[31] == be[31]) && (rr[31] != a[31]);
    return {ov, rr[32], rr[31:0]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_ops('0, '0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 32'h0) begin n_bad++; $display("FAIL reset_out_sum got %h want 0", bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b0) begin n_bad++; $display("FAIL reset_out_cout got %b want 0", bus.out_cout); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf got %b want 0", bus.out_ovf); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_carry_chain;
    bit acc, pop, pc, po;
    logic [31:0] ps;
    set_ops(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick(acc, pop, ps, pc, po);
    bus.in_valid = 1'b0;
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL carry_accept got %b want 1", acc); end
    for (int e = 1; e <= 3; e++) begin
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL carry_latency edge %0d out_valid got %b want 0", e - 1, bus.out_valid); end
      tick(acc, pop, ps, pc, po);
    end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL carry_latency edge 3 out_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 32'h0) begin n_bad++; $display("FAIL carry_sum got %h want 00000000", bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b1) begin n_bad++; $display("FAIL carry_cout got %b want 1", bus.out_cout); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL carry_ovf got %b want 0", bus.out_ovf); end
    tick(acc, pop, ps, pc, po);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL carry_single_emit out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_overflow;
    logic [31:0] s; bit co, ov, got;
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, got);
    n_cmp++; if (!got || s !== 32'h8000_0000 || co !== 1'b0 || ov !== 1'b1) begin
      n_bad++; $display("FAIL ovf_pos got valid=%b sum=%h cout=%b ovf=%b want sum=80000000 cout=0 ovf=1", got, s, co, ov);
    end
    run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, s, co, ov, got);
    n_cmp++; if (!got || s !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
      n_bad++; $display("FAIL ovf_neg got valid=%b sum=%h cout=%b ovf=%b want sum=7fffffff cout=1 ovf=1", got, s, co, ov);
    end
  endtask

  task automatic test_subtract;
    logic [31:0] s; bit co, ov, got;
    run_one(32'd5, 32'd7, 1'b1, 1'b1, s, co, ov, got);
    n_cmp++; if (!got || s !== 32'hFFFF_FFFE || co !== 1'b0 || ov !== 1'b0) begin
      n_bad++; $display("FAIL sub_5_7 got valid=%b sum=%h cout=%b ovf=%b want sum=fffffffe cout=0 ovf=0", got, s, co, ov);
    end
    run_one(32'd7, 32'd5, 1'b0, 1'b1, s, co, ov, got);
    n_cmp++; if (!got || s !== 32'h0000_0002 || co !== 1'b1 || ov !== 1'b0) begin
      n_bad++; $display("FAIL sub_7_5 got valid=%b sum=%h cout=%b ovf=%b want sum=00000002 cout=1 ovf=0", got, s, co, ov);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] bp_a [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    logic [31:0] bp_s [6] = '{32'h111, 32'h211, 32'h311, 32'h411, 32'h511, 32'h611};
    bit acc, pop, pc, po;
    logic [31:0] ps, held;
    int idx, npop, prev_c;
    idx = 0; npop = 0; prev_c = 0;
    bus.out_ready = 1'b0;
    set_ops(bp_a[0], 32'h11, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(acc, pop, ps, pc, po);
      if (acc) begin
        idx++;
        if (idx < 6) bus.in_a = bp_a[idx]; else bus.in_valid = 1'b0;
      end
    end
    n_cmp++; if (idx != 4) begin n_bad++; $display("FAIL bp_accept_count got %0d want 4", idx); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== bp_s[0]) begin
      n_bad++; $display("FAIL bp_head got valid=%b sum=%h want valid=1 sum=%h", bus.out_valid, bus.out_sum, bp_s[0]);
    end
    held = bus.out_sum;
    tick(acc, pop, ps, pc, po);
    tick(acc, pop, ps, pc, po);
    n_cmp++; if (bus.out_sum !== held) begin n_bad++; $display("FAIL bp_stall_hold got %h want %h", bus.out_sum, held); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && npop < 6; c++) begin
      tick(acc, pop, ps, pc, po);
      if (acc) begin
        idx++;
        if (idx < 6) bus.in_a = bp_a[idx]; else bus.in_valid = 1'b0;
      end
      if (pop) begin
        n_cmp++; if (ps !== bp_s[npop]) begin n_bad++; $display("FAIL bp_order[%0d] got %h want %h", npop, ps, bp_s[npop]); end
        if (npop > 0) begin
          n_cmp++; if (c != prev_c + 1) begin n_bad++; $display("FAIL bp_rate[%0d] cycle got %0d want %0d", npop, c, prev_c + 1); end
        end
        prev_c = c;
        npop++;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (npop != 6 || idx != 6) begin n_bad++; $display("FAIL bp_drain got popped=%0d accepted=%0d want 6/6", npop, idx); end
  endtask

  task automatic test_streaming;
    logic [33:0] exp_q [$];
    logic [33:0] e;
    bit acc, pop, pc, po;
    logic [31:0] ps;
    int sent, got, bad_before;
    sent = 0; got = 0; bad_before = n_bad;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      if (!bus.in_valid && sent < 1000) begin
        set_ops(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom(),
                ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick(acc, pop, ps, pc, po);
      if (acc) begin
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
        sent++;
        bus.in_valid = 1'b0;
      end
      if (pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra result %h with nothing outstanding", ps);
        end else begin
          e = exp_q.pop_front();
          if ({po, pc, ps} !== e) begin
            n_bad++; $display("FAIL stream[%0d] got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                              got, po, pc, ps, e[33], e[32], e[31:0]);
          end
        end
        got++;
      end
      if (n_bad - bad_before > 10) break;
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got != 1000 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL stream_count got %0d results (%0d outstanding) want 1000 (0)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    bit acc, pop, pc, po;
    logic [31:0] ps;
    int nacc, npop;
    logic [31:0] s; bit co, ov, gotr;
    nacc = 0; npop = 0;
    bus.out_ready = 1'b0;
    set_ops(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(acc, pop, ps, pc, po);
      if (acc) nacc++;
    end
    bus.in_valid = 1'b0;
    tick(acc, pop, ps, pc, po);
    n_cmp++; if (nacc != 3 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_fill got accepted=%0d out_valid=%b want 3/1", nacc, bus.out_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 32'h0) begin
      n_bad++; $display("FAIL rst_async got out_valid=%b sum=%h want 0/00000000", bus.out_valid, bus.out_sum);
    end
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < 8; i++) begin
      tick(acc, pop, ps, pc, po);
      if (pop) npop++;
    end
    n_cmp++; if (npop != 0) begin n_bad++; $display("FAIL rst_stale got %0d results want 0", npop); end
    run_one(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, s, co, ov, gotr);
    n_cmp++; if (!gotr || s !== 32'h0000_0101 || co !== 1'b0 || ov !== 1'b0) begin
      n_bad++; $display("FAIL rst_recover got valid=%b sum=%h cout=%b ovf=%b want sum=00000101 cout=0 ovf=0", gotr, s, co, ov);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
